// File: rtl/shared_timer_arb.sv
// Shared up-counter timer with a round-robin arbiter in front of it.
// The winner's terminal count is latched at grant, and a 1-clk done strobe goes back to the owner.
module shared_timer_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] ld_val,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [DW-1:0]      cntr
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_last;
    logic [IW-1:0]   sel;
    logic [DW-1:0]   term;

    // Scan from farthest to nearest, so the requester closest after rr_last wins.
    always_comb begin
        sel = '0;
        for (int unsigned i = NREQ; i >= 1; i--) begin
            if (req[(32'(rr_last) + i) % NREQ])
                sel = IW'((32'(rr_last) + i) % NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= '0;
            rr_last <= IW'(NREQ - 1);
            term    <= '0;
            cntr    <= '0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (|req) begin
                        owner   <= sel;
                        rr_last <= sel;
                        term    <= ld_val[sel*DW +: DW];
                        cntr    <= '0;
                        gnt     <= NREQ'(1) << sel;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // A dropped request aborts the run, even when the count is already at term.
                    if (!req[owner]) begin
                        gnt   <= '0;
                        cntr  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cntr == term) begin
                        done  <= NREQ'(1) << owner;
                        gnt   <= '0;
                        cntr  <= '0;
                        state <= DONE;
                    end else begin
                        cntr <= cntr + DW'(1);
                    end
                end
                DONE: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_timer_arb.sv
// Bench for shared_timer_arb: directed scenarios with literal expectations,
// then random traffic compared every cycle against an ownership-level model.
module tb_shared_timer_arb;

    localparam int NREQ = 4;
    localparam int DW   = 12;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] ld_val;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [DW-1:0]      cntr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: who owns the timer, how far it has counted, and whether a done is showing.
    int m_owner;
    int m_rr;
    int m_cnt;
    int m_term;
    int m_done_idx;
    bit m_indone;

    shared_timer_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .ld_val (ld_val),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cntr   (cntr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_owner  = -1;
            m_rr     = NREQ - 1;
            m_cnt    = 0;
            m_indone = 0;
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_cnt   = 0;
            end else if (m_cnt == m_term) begin
                m_done_idx = m_owner;
                m_indone   = 1;
                m_owner    = -1;
                m_cnt      = 0;
            end else begin
                m_cnt++;
            end
        end else if (m_indone) begin
            m_indone = 0;
        end else if (req != '0) begin
            for (int i = 1; i <= NREQ; i++) begin
                int j;
                j = (m_rr + i) % NREQ;
                if (req[j]) begin
                    m_owner = j;
                    break;
                end
            end
            m_rr   = m_owner;
            m_term = int'(ld_val[m_owner*DW +: DW]);
            m_cnt  = 0;
        end
    endtask

    task automatic compare_model();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ed;
        eg = '0;
        ed = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        if (m_indone) ed[m_done_idx] = 1'b1;
        check("gnt",  32'(gnt),  32'(eg));
        check("done", 32'(done), 32'(ed));
        check("busy", 32'(busy), 32'((m_owner >= 0) || m_indone));
        check("cntr", 32'(cntr), 32'(m_cnt));
    endtask

    // One clock: model follows the edge, then DUT vs model away from the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_model();
    endtask

    task automatic set_term(input int i, input int v);
        ld_val[i*DW +: DW] = DW'(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        req    = '0;
        ld_val = '0;
        @(negedge clk);
        do_reset();
        check("rst_gnt",  32'(gnt),  0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cntr", 32'(cntr), 0);

        // Single requester, term 5: grant at 1, count 0..5 at 1..6, done at 7 only.
        set_term(0, 5);
        req = 4'b0001;
        tick();
        check("t1_gnt1", 32'(gnt), 32'h1);
        check("t1_cnt1", 32'(cntr), 0);
        for (int k = 2; k <= 6; k++) tick();
        check("t1_cnt6", 32'(cntr), 5);
        check("t1_done6", 32'(done), 0);
        tick();
        check("t1_done7", 32'(done), 32'h1);
        check("t1_gnt7",  32'(gnt), 0);
        check("t1_busy7", 32'(busy), 1);
        tick();
        check("t1_done8", 32'(done), 0);
        check("t1_busy8", 32'(busy), 0);
        req = '0;
        tick();

        // All requesting with term 0: round-robin 0,1,2,3,0 with one idle clock between owners.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_term(i, 0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_gnt", 32'(gnt), 32'(1 << (k % NREQ)));
            tick();
            check("t2_done", 32'(done), 32'(1 << (k % NREQ)));
            tick();
            check("t2_idle", 32'(busy), 0);
        end
        req = '0;
        tick();

        // Abort of a long run at cntr 40.
        do_reset();
        set_term(2, 100);
        req = 4'b0100;
        tick();
        for (int k = 0; k < 40; k++) tick();
        check("t3_cnt40", 32'(cntr), 40);
        req = '0;
        tick();
        check("t3_gnt", 32'(gnt), 0);
        check("t3_cnt", 32'(cntr), 0);
        check("t3_done", 32'(done), 0);
        tick();
        check("t3_done2", 32'(done), 0);

        // Drop on the cycle cntr==term: abort wins, no done.
        set_term(1, 3);
        req = 4'b0010;
        tick();
        for (int k = 0; k < 3; k++) tick();
        check("t4_cnt", 32'(cntr), 3);
        req = '0;
        tick();
        check("t4_done", 32'(done), 0);
        check("t4_busy", 32'(busy), 0);
        tick();
        check("t4_done2", 32'(done), 0);

        // Reset mid-run, then requester 0 wins first.
        set_term(3, 20);
        req = 4'b1000;
        tick();
        for (int k = 0; k < 7; k++) tick();
        check("t5_cnt7", 32'(cntr), 7);
        reset = 1'b1;
        req   = 4'b1001;
        tick();
        check("t5_gnt", 32'(gnt), 0);
        check("t5_cntr", 32'(cntr), 0);
        check("t5_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();
        check("t5_first", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();

        // Full-scale term with ld_val changed mid-run.
        do_reset();
        set_term(0, (1 << DW) - 1);
        req = 4'b0001;
        tick();
        for (int k = 1; k <= (1 << DW) - 1; k++) begin
            tick();
            if (k == 100) set_term(0, 10);
        end
        check("t6_cntmax", 32'(cntr), 32'((1 << DW) - 1));
        tick();
        check("t6_done", 32'(done), 32'h1);
        check("t6_cntr0", 32'(cntr), 0);
        req = '0;
        tick();

        // Random traffic: slowly toggling requests, short terms, rare resets.
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(15) == 0) req[i] = ~req[i];
                if ($urandom_range(3) == 0) set_term(i, int'($urandom_range(6)));
            end
            reset = ($urandom_range(400) == 0);
            tick();
        end
        reset = 1'b0;
        req   = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
